// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports and two bypassed
// read ports. It tracks which registers have a result outstanding, and it
// zeroes the whole array by walking every address after reset or a soft clear.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              pend1,
  output logic              pend2
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [NREG-1:0]   r_pend;
  logic [DATA_W-1:0] r_mem [NREG];

  logic              w_zr;
  logic              w_run;
  logic              w_upd;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_alloc;
  logic [NREG-1:0]   w_pend_nxt;

  assign w_zr  = (ZERO_R0 != 0);
  assign w_run = (r_state == ST_RUN);
  // Normal RUN cycle: a clear request discards every write and alloc in its cycle.
  assign w_upd = w_run && !clr_req;

  assign w_acc0  = w_upd && we0 && !(w_zr && (wa0 == '0));
  assign w_acc1  = w_upd && we1 && !(w_zr && (wa1 == '0));
  assign w_alloc = w_upd && alloc_en && !(w_zr && (alloc_addr == '0));

  assign ready = w_run;

  // State and clear counter: INIT walks every address once, then RUN until a clear request.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) r_state <= ST_RUN;
    end else if (clr_req) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end
  end

  // Array storage has no reset; INIT zeroes it one entry per cycle.
  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge cpu_clk_50M) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_acc0) r_mem[wa0] <= wd0;
      if (w_acc1) r_mem[wa1] <= wd1;
    end
  end

  // Next pending vector: writes clear their bit, then an alloc sets its bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_acc0)  w_pend_nxt[wa0] = 1'b0;
    if (w_acc1)  w_pend_nxt[wa1] = 1'b0;
    if (w_alloc) w_pend_nxt[alloc_addr] = 1'b1;
  end

  // Pending bits: cleared by reset and on the edge that enters INIT, frozen during INIT.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_pend <= '0;
    end else if (w_run) begin
      if (clr_req) r_pend <= '0;
      else         r_pend <= w_pend_nxt;
    end
  end

  // Read port 1: zero when idle or in INIT, otherwise write-bypassed array read.
  always_comb begin
    rd1 = '0;
    if (w_run && re1 && !(w_zr && (ra1 == '0))) begin
      if (we1 && (wa1 == ra1))      rd1 = wd1;
      else if (we0 && (wa0 == ra1)) rd1 = wd0;
      else                          rd1 = r_mem[ra1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd2 = '0;
    if (w_run && re2 && !(w_zr && (ra2 == '0))) begin
      if (we1 && (wa1 == ra2))      rd2 = wd1;
      else if (we0 && (wa0 == ra2)) rd2 = wd0;
      else                          rd2 = r_mem[ra2];
    end
  end

  // Pending status: a write landing this cycle already resolves the register.
  always_comb begin
    pend1 = w_run && r_pend[ra1] && !(w_acc0 && (wa0 == ra1)) && !(w_acc1 && (wa1 == ra1));
    pend2 = w_run && r_pend[ra2] && !(w_acc0 && (wa0 == ra2)) && !(w_acc1 && (wa1 == ra2));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (32 x 32-bit, register 0 hardwired).
// Inputs change on the falling edge; outputs are sampled a few time units later.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        ready;
  logic        we0, we1, re1, re2, alloc_en;
  logic [4:0]  wa0, wa1, ra1, ra2, alloc_addr;
  logic [31:0] wd0, wd1, rd1, rd2;
  logic        pend1, pend2;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  logic [31:0] acc;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (rst),
    .clr_req    (clr_req),
    .ready      (ready),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .re1        (re1),
    .ra1        (ra1),
    .rd1        (rd1),
    .re2        (re2),
    .ra2        (ra2),
    .rd2        (rd2),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .pend1      (pend1),
    .pend2      (pend2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Count rising edges until ready rises, giving up after 100.
  task automatic count_init(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    re1 = 1'b1; ra1 = 5'd5; re2 = 1'b1; ra2 = 5'd6;
    alloc_en = 1'b0; alloc_addr = '0;

    #1;
    check("rst_ready", ready, 0);
    check("rst_rd1", rd1, 0);
    check("rst_pend1", pend1, 0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    count_init(n);
    check("init_len", n, 32);

    @(negedge clk);
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      acc = acc | rd1 | rd2;
    end
    check("all_zero", acc, 0);

    // Port 0 write bypass, read enable off
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5; ra1 = 5'd3; ra2 = 5'd3; re2 = 1'b0;
    #1;
    check("byp_w0", rd1, 32'hA5A5A5A5);
    check("re2_off", rd2, 0);
    @(negedge clk);
    we0 = 1'b0; re2 = 1'b1;
    #1;
    check("arr_r3", rd1, 32'hA5A5A5A5);
    check("arr_r3_p2", rd2, 32'hA5A5A5A5);

    // Same-address collision: port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222; ra1 = 5'd7;
    #1;
    check("same_byp", rd1, 32'h22222222);
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    check("same_arr", rd1, 32'h22222222);

    // Two writes to distinct addresses
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAAAA0010;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hBBBB0011; ra1 = 5'd10; ra2 = 5'd11;
    #1;
    check("dual_byp1", rd1, 32'hAAAA0010);
    check("dual_byp2", rd2, 32'hBBBB0011);
    @(negedge clk);
    we0 = 1'b0; we1 = 1'b0;
    #1;
    check("dual_arr1", rd1, 32'hAAAA0010);
    check("dual_arr2", rd2, 32'hBBBB0011);

    // Pending tracking
    alloc_en = 1'b1; alloc_addr = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    check("pend_pre", pend1, 0);
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    check("pend_set", pend1, 1);
    check("pend_set2", pend2, 1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h00000099;
    #1;
    check("pend_wrclr", pend1, 0);
    @(negedge clk);
    we0 = 1'b0;
    #1;
    check("pend_stay0", pend1, 0);
    alloc_en = 1'b1; alloc_addr = 5'd9; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000009A;
    @(negedge clk);
    alloc_en = 1'b0; we1 = 1'b0;
    #1;
    check("pend_alloc_wr", pend1, 1);
    check("pend_alloc_wd", rd1, 32'h0000009A);
    alloc_en = 1'b1; alloc_addr = 5'd0; ra2 = 5'd0;
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    check("pend_r0", pend2, 0);

    // Register 0 stays zero
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("r0_byp", rd1, 0);
    @(negedge clk);
    we0 = 1'b0;
    #1;
    check("r0_arr", rd1, 0);

    // Soft clear
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h00000005;
    @(negedge clk);
    we0 = 1'b0; ra1 = 5'd4; ra2 = 5'd9;
    #1;
    check("r4_w", rd1, 32'h00000005);
    check("p9_before_clr", pend2, 1);
    clr_req = 1'b1; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h00000066;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000DEAD; wd1 = 32'h0000BEEF;
    #1;
    check("clr_ready", ready, 0);
    check("init_rd", rd1, 0);
    check("init_pend", pend2, 0);
    count_init(n);
    check("clr_len", n, 32);
    #1;
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    #1;
    check("clr_r4", rd1, 0);
    check("clr_pend9", pend2, 0);
    check("init_alloc_ign", pend1, 0);

    // Reset in the middle of INIT (cnt = 15)
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_ready", ready, 0);
    check("mid_rd1", rd1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_init(n);
    check("mid_len", n, 32);

    // Asynchronous reset while in RUN
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h12345678;
    alloc_en = 1'b1; alloc_addr = 5'd21;
    @(negedge clk);
    we0 = 1'b0; alloc_en = 1'b0; ra1 = 5'd20; ra2 = 5'd21;
    #1;
    check("run_rd1", rd1, 32'h12345678);
    check("run_pend2", pend2, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_ready", ready, 0);
    check("async_rd1", rd1, 0);
    check("async_pend2", pend2, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_init(n);
    check("run_rst_len", n, 32);
    #1;
    check("run_rst_r20", rd1, 0);
    check("run_rst_p21", pend2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
